// File: rtl/vga_status_renderer.sv
// Colour stage behind the VGA timing generator: draws the conveyor status screen
// from per-frame shadowed status, with a 2-stage pixel pipeline and matched sync delay.
module vga_status_renderer #(
    parameter logic H_POL       = 1'b0,
    parameter logic V_POL       = 1'b0,
    parameter int   SCROLL_STEP = 2,
    parameter int   BAR_STEP    = 4,
    parameter int   BAR_MAX_COL = 600
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        disp_ena,
    input  logic [31:0] column,
    input  logic [31:0] row,
    input  logic [7:0]  bottle_count,
    input  logic        bottle_present,
    input  logic        conveyor_run,
    input  logic        alarm,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        h_sync,
    output logic        v_sync
);

    logic        r_vsD;
    logic [7:0]  r_countSh;
    logic        r_presentSh;
    logic        r_runSh;
    logic        r_alarmSh;
    logic [7:0]  r_frameCnt;
    logic [4:0]  r_scroll;

    logic        r_s1Border, r_s1Bottle, r_s1Bar, r_s1Belt, r_s1Stripe;
    logic        r_s1De, r_s1Hs, r_s1Vs;

    logic        w_frameStart;
    logic [11:0] w_barEnd;
    logic [11:0] w_barLimit;
    logic [4:0]  w_stripeSum;
    logic        w_inBorder, w_inBottle, w_inBar, w_inBelt, w_stripe;
    logic        w_blinkOn;
    logic [11:0] w_rgb;

    assign w_frameStart = (v_sync_in == V_POL) && (r_vsD != V_POL);

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vsD <= ~V_POL;
        end else begin
            r_vsD <= v_sync_in;
        end
    end

    // Status is frozen once per frame; scroll advances on the previous frame's run flag.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_countSh   <= 8'd0;
            r_presentSh <= 1'b0;
            r_runSh     <= 1'b0;
            r_alarmSh   <= 1'b0;
            r_frameCnt  <= 8'd0;
            r_scroll    <= 5'd0;
        end else if (w_frameStart) begin
            r_countSh   <= bottle_count;
            r_presentSh <= bottle_present;
            r_runSh     <= conveyor_run;
            r_alarmSh   <= alarm;
            r_frameCnt  <= r_frameCnt + 8'd1;
            if (r_runSh) begin
                r_scroll <= r_scroll + 5'(SCROLL_STEP);
            end
        end
    end

    assign w_barEnd    = 12'd40 + 12'(BAR_STEP) * {4'd0, r_countSh};
    assign w_barLimit  = (w_barEnd > 12'(BAR_MAX_COL)) ? 12'(BAR_MAX_COL) : w_barEnd;
    assign w_stripeSum = column[4:0] + r_scroll;
    assign w_stripe    = (w_stripeSum < 5'd16);

    assign w_inBorder = (column < 32'd8) || (column > 32'd631) || (row < 32'd8) || (row > 32'd471);
    assign w_inBottle = (column >= 32'd300) && (column <= 32'd339) && (row >= 32'd220) && (row <= 32'd299);
    assign w_inBar    = (row >= 32'd40) && (row <= 32'd59) && (column >= 32'd40) && (column < {20'd0, w_barLimit});
    assign w_inBelt   = (row >= 32'd300) && (row <= 32'd339);

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1Border <= 1'b0;
            r_s1Bottle <= 1'b0;
            r_s1Bar    <= 1'b0;
            r_s1Belt   <= 1'b0;
            r_s1Stripe <= 1'b0;
            r_s1De     <= 1'b0;
            r_s1Hs     <= ~H_POL;
            r_s1Vs     <= ~V_POL;
        end else begin
            r_s1Border <= w_inBorder;
            r_s1Bottle <= w_inBottle;
            r_s1Bar    <= w_inBar;
            r_s1Belt   <= w_inBelt;
            r_s1Stripe <= w_stripe;
            r_s1De     <= disp_ena;
            r_s1Hs     <= h_sync_in;
            r_s1Vs     <= v_sync_in;
        end
    end

    // A blanked border falls through to whatever lies beneath it.
    assign w_blinkOn = r_alarmSh && !r_frameCnt[4];

    always_comb begin
        w_rgb = 12'h000;
        if (!r_s1De) begin
            w_rgb = 12'h000;
        end else if (r_s1Border && w_blinkOn) begin
            w_rgb = 12'hF00;
        end else if (r_s1Bottle && r_presentSh) begin
            w_rgb = 12'h0C0;
        end else if (r_s1Bar) begin
            w_rgb = 12'h00F;
        end else if (r_s1Belt) begin
            w_rgb = r_s1Stripe ? 12'h888 : 12'h444;
        end else begin
            w_rgb = 12'h012;
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            red    <= 4'd0;
            green  <= 4'd0;
            blue   <= 4'd0;
            h_sync <= ~H_POL;
            v_sync <= ~V_POL;
        end else begin
            red    <= w_rgb[11:8];
            green  <= w_rgb[7:4];
            blue   <= w_rgb[3:0];
            h_sync <= r_s1Hs;
            v_sync <= r_s1Vs;
        end
    end

endmodule

// File: tb/tb_vga_status_renderer.sv
// Randomised scoreboard bench for vga_status_renderer: a frame-level reference model
// predicts each pixel's colour and sync, and a monitor compares two cycles later.
module tb_vga_status_renderer;

    localparam logic H_POL       = 1'b0;
    localparam logic V_POL       = 1'b0;
    localparam int   SCROLL_STEP = 2;
    localparam int   BAR_STEP    = 4;
    localparam int   BAR_MAX_COL = 600;

    logic        pixel_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        h_sync_in = 1'b1;
    logic        v_sync_in = 1'b1;
    logic        disp_ena = 1'b0;
    logic [31:0] column = '0;
    logic [31:0] row = '0;
    logic [7:0]  bottle_count = '0;
    logic        bottle_present = 1'b0;
    logic        conveyor_run = 1'b0;
    logic        alarm = 1'b0;
    logic [3:0]  red, green, blue;
    logic        h_sync, v_sync;

    vga_status_renderer #(
        .H_POL(H_POL), .V_POL(V_POL), .SCROLL_STEP(SCROLL_STEP),
        .BAR_STEP(BAR_STEP), .BAR_MAX_COL(BAR_MAX_COL)
    ) dut (
        .pixel_clk(pixel_clk), .reset_n(reset_n),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in), .disp_ena(disp_ena),
        .column(column), .row(row),
        .bottle_count(bottle_count), .bottle_present(bottle_present),
        .conveyor_run(conveyor_run), .alarm(alarm),
        .red(red), .green(green), .blue(blue),
        .h_sync(h_sync), .v_sync(v_sync)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        int         due;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } entry_t;

    entry_t q[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    // Frame-level reference state: what the screen should reflect this frame.
    int   mCount, mPresent, mRun, mAlarm, mFrame, mScroll;
    logic mVsD;

    int unsigned ptCol[12] = '{100, 79, 80, 599, 600, 14, 4, 320, 320, 3, 636, 40};
    int unsigned ptRow[12] = '{100, 50, 50, 50, 50, 320, 4, 250, 320, 310, 200, 50};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    always @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            mCount <= 0; mPresent <= 0; mRun <= 0; mAlarm <= 0;
            mFrame <= 0; mScroll <= 0; mVsD <= ~V_POL;
        end else begin
            if (v_sync_in == V_POL && mVsD != V_POL) begin
                mCount   <= int'(bottle_count);
                mPresent <= int'(bottle_present);
                mRun     <= int'(conveyor_run);
                mAlarm   <= int'(alarm);
                mFrame   <= (mFrame + 1) % 256;
                mScroll  <= (mRun != 0) ? (mScroll + SCROLL_STEP) % 32 : mScroll;
            end
            mVsD <= v_sync_in;
        end
    end

    function automatic logic [11:0] modelColour(input logic de, input logic [31:0] col, input logic [31:0] rw);
        longint c = longint'(col);
        longint r = longint'(rw);
        longint barEnd = 40 + BAR_STEP * mCount;
        if (barEnd > BAR_MAX_COL) barEnd = BAR_MAX_COL;
        if (!de) return 12'h000;
        if ((c < 8 || c > 631 || r < 8 || r > 471) && mAlarm != 0 && ((mFrame / 16) % 2 == 0))
            return 12'hF00;
        if (mPresent != 0 && c >= 300 && c <= 339 && r >= 220 && r <= 299) return 12'h0C0;
        if (r >= 40 && r <= 59 && c >= 40 && c < barEnd) return 12'h00F;
        if (r >= 300 && r <= 339) return (((c % 32) + mScroll) % 32 < 16) ? 12'h888 : 12'h444;
        return 12'h012;
    endfunction

    task automatic applyStimulus(input logic de, input logic [31:0] col, input logic [31:0] rw,
                                 input logic hs, input logic vs);
        entry_t e;
        @(negedge pixel_clk);
        disp_ena = de; column = col; row = rw; h_sync_in = hs; v_sync_in = vs;
        e.due = cyc + 2;
        e.rgb = modelColour(de, col, rw);
        e.hs  = hs;
        e.vs  = vs;
        q.push_back(e);
    endtask

    task automatic randomPixel();
        int k = int'($urandom % 20);
        logic [31:0] col, rw;
        if (k < 12) begin
            col = ptCol[k]; rw = ptRow[k];
        end else if (k == 19) begin
            col = 32'hFFFF_FFE0 + ($urandom % 32); rw = $urandom % 500;
        end else begin
            col = $urandom % 700; rw = $urandom % 500;
        end
        applyStimulus(($urandom % 8) != 0, col, rw, 1'($urandom % 2), 1'b1);
    endtask

    task automatic randStatus();
        case ($urandom % 4)
            0: bottle_count = 8'd0;
            1: bottle_count = 8'd10;
            2: bottle_count = 8'd255;
            default: bottle_count = 8'($urandom);
        endcase
        bottle_present = 1'($urandom % 2);
        conveyor_run   = ($urandom % 4) != 0;
        alarm          = ($urandom % 4) != 0;
    endtask

    task automatic runFrame(input int nPix, input bit doRand);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, V_POL);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, ~V_POL);
        for (int i = 0; i < nPix; i++) begin
            if (doRand && ($urandom % 6 == 0)) randStatus();
            randomPixel();
        end
    endtask

    always @(posedge pixel_clk) begin
        entry_t e;
        cyc <= cyc + 1;
        #1;
        if (reset_n) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                e = q.pop_front();
                checkOutput("missed_slot", 32'(cyc), 32'(e.due));
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                checkOutput("rgb", {20'd0, red, green, blue}, {20'd0, e.rgb});
                checkOutput("h_sync", {31'd0, h_sync}, {31'd0, e.hs});
                checkOutput("v_sync", {31'd0, v_sync}, {31'd0, e.vs});
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge pixel_clk);
        #1;
        checkOutput("reset_rgb", {20'd0, red, green, blue}, 32'd0);
        checkOutput("reset_hs", {31'd0, h_sync}, {31'd0, ~H_POL});
        checkOutput("reset_vs", {31'd0, v_sync}, {31'd0, ~V_POL});
        @(negedge pixel_clk);
        reset_n = 1'b1;

        applyStimulus(1'b1, 32'd100, 32'd100, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd100, 32'd100, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'd100, 32'd100, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd200, 32'd100, 1'b1, 1'b1);

        // Mid-line asynchronous reset with vertical sync already active.
        @(negedge pixel_clk);
        #2;
        reset_n = 1'b0;
        v_sync_in = V_POL; disp_ena = 1'b0; h_sync_in = 1'b1;
        q.delete();
        #1;
        checkOutput("midreset_rgb", {20'd0, red, green, blue}, 32'd0);
        checkOutput("midreset_hs", {31'd0, h_sync}, {31'd0, ~H_POL});
        checkOutput("midreset_vs", {31'd0, v_sync}, {31'd0, ~V_POL});
        repeat (2) @(posedge pixel_clk);
        #1;
        checkOutput("held_reset_rgb", {20'd0, red, green, blue}, 32'd0);
        @(negedge pixel_clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, V_POL);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, ~V_POL);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, ~V_POL);

        applyStimulus(1'b1, 32'd79, 32'd50, 1'b1, 1'b1);
        bottle_count = 8'd10;
        applyStimulus(1'b1, 32'd79, 32'd50, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd80, 32'd50, 1'b1, 1'b1);
        runFrame(0, 1'b0);
        applyStimulus(1'b1, 32'd79, 32'd50, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'd80, 32'd50, 1'b1, 1'b1);

        bottle_count = 8'd255;
        runFrame(0, 1'b0);
        applyStimulus(1'b1, 32'd599, 32'd50, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'd600, 32'd50, 1'b1, 1'b1);

        conveyor_run = 1'b1;
        for (int f = 0; f < 4; f++) begin
            runFrame(0, 1'b0);
            applyStimulus(1'b1, 32'd14, 32'd320, 1'b1, 1'b1);
            applyStimulus(1'b1, 32'd2, 32'd330, 1'b1, 1'b1);
        end

        alarm = 1'b1; bottle_present = 1'b1;
        for (int f = 0; f < 40; f++) begin
            runFrame(14, (f % 3) == 2);
            applyStimulus(1'b1, 32'd100, 32'd4, 1'b1, 1'b1);
            applyStimulus(1'b1, 32'd320, 32'd250, 1'b1, 1'b1);
            applyStimulus(1'b0, 32'd320, 32'd250, 1'b1, 1'b1);
            if ((f % 3) == 2) begin
                alarm = 1'b1;
                bottle_present = 1'b1;
            end
        end

        repeat (4) @(negedge pixel_clk);
        checkOutput("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_status_renderer.md
# vga_status_renderer

Pixel-colour stage placed directly downstream of the VGA timing generator. It consumes the generator's sync, display-enable and pixel coordinates and produces 12-bit RGB for the conveyor status screen: an animated belt, a bottle marker, a bottle-count bar and a blinking alarm border. Status inputs are sampled once per frame at the vertical-sync edge, so a frame never shows a mix of old and new status. Output sync is delayed to match the 2-stage colour pipeline.

## Interface
- H_POL, 1'b0, horizontal sync active level; must match the timing generator.
- V_POL, 1'b0, vertical sync active level; must match the timing generator.
- SCROLL_STEP, 2, belt stripe offset added per frame while running (0..31).
- BAR_STEP, 4, bar pixels per counted bottle.
- BAR_MAX_COL, 600, right-hand clamp column for the count bar.

Ports:
- pixel_clk  in  1  pixel clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- h_sync_in  in  1  horizontal sync from the timing generator.
- v_sync_in  in  1  vertical sync from the timing generator.
- disp_ena  in  1  active-video flag from the timing generator.
- column  in  32  horizontal pixel coordinate (0 outside active video).
- row  in  32  vertical pixel coordinate.
- bottle_count  in  8  bottles processed; may change at any time.
- bottle_present  in  1  bottle at the filling station.
- conveyor_run  in  1  belt motor running.
- alarm  in  1  fault flag.
- red, green, blue  out  4 each  pixel colour.
- h_sync, v_sync  out  1 each  sync outputs, delayed 2 cycles.

## Operation
- Frame latch: v_sync_in is registered as vs_d. The frame-start pulse is v_sync_in==V_POL && vs_d!=V_POL. On that pulse:
  - bottle_count, bottle_present, conveyor_run and alarm are copied into shadow registers.
  - The 8-bit frame_cnt increments and wraps 255→0.
  - If the shadowed conveyor_run (the value before this update) is 1, the 5-bit scroll does scroll+SCROLL_STEP mod 32.
- Rendering uses the shadow values only.
- Stage 1 (registered) decodes regions from column and row (full 32-bit compares, inclusive bounds):
  - border: column<8 or column>631 or row<8 or row>471.
  - bottle: column 300..339, row 220..299.
  - bar: row 40..59 and 40 ≤ column < min(40+BAR_STEP*count, BAR_MAX_COL); computed at ≥11-bit width with no overflow. count=0 gives no bar.
  - belt: row 300..339. stripe = ((column[4:0]+scroll) mod 32) < 16.
  - disp_ena, h_sync_in and v_sync_in are carried along.
- Stage 2 (registered) selects colour, first match wins:
  - if disp_ena is low, colour is 000.
  - border when alarm_sh && frame_cnt[4]==0: F00.
  - bottle when present_sh: 0C0.
  - bar: 00F.
  - belt, stripe: 888; belt, no stripe: 444.
  - anything else: 012.
- Alarm blink: 32-frame period, 16 frames on and 16 off. The border region shows background colour while blanked.

## Timing
- Latency: a coordinate presented at cycle N appears on RGB at N+2. h_sync and v_sync are the inputs delayed by exactly 2 cycles.
- Shadow registers and frame_cnt update on the clock edge of the frame-start pulse cycle. The first pixel of the next active frame always sees the new values.
- Status changes at any time other than the pulse have no effect until the next pulse.
- Reset (asynchronous, any cycle, including mid-line):
  - RGB = 0.
  - h_sync = ~H_POL, v_sync = ~V_POL, and both pipeline sync stages are set to the same values.
  - vs_d = ~V_POL.
  - Shadows, frame_cnt and scroll = 0.
- After reset release, rendering restarts on the next cycle with no spurious frame-start pulse unless v_sync_in is already at V_POL. If it is, a pulse fires on the first cycle after release.

## Test plan
- Reset mid-line with v_sync_in=V_POL held → all outputs at reset values immediately. After release, one frame-start pulse occurs and frame_cnt becomes 1.
- Latency: drive disp_ena=1, column=100, row=100, no status → RGB=012 exactly 2 cycles later. Toggle h_sync_in → h_sync follows 2 cycles later.
- Frame latch: change bottle_count 0→10 mid-frame → no bar until after the next pulse. Then row 50: column 79 = 00F, column 80 = 012.
- Bar clamp: bottle_count=255 → row 50, column 599 = 00F, column 600 = 012.
- Scroll: conveyor_run=1, SCROLL_STEP=2, over 3 frames → scroll goes 0, 2, 4 (0, 0, 2 relative to the shadow lag). Row 320 column 14 changes from 888 to 444 as predicted.
- Alarm and priority: alarm=1, bottle_present=1 → row 4 = F00 for frame_cnt 0..15 and 012 for 16..31. Row 250 column 320 = 0C0. disp_ena=0 → 000 in all cases.
